// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, qualifies lock, then releases
// the clk0 and clk1 domain resets in order. Re-runs the sequence on loss of
// lock and reports status to the MCU register block.
// Optional build macro: PLL_SEQ_FAULT_EN enables the FAULT state, which is
// entered after MAX_RETRIES failed lock attempts.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES = 100,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int LOCK_STABLE     = 1024,
    parameter int RELEASE_GAP     = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int CNT_W           = 16
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       rst_out0,
    output logic       rst_out1,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic       fault
);

`ifdef PLL_SEQ_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // Terminal counter values. HOLD/timeout/gap compare against N-1 so the
    // state lasts exactly N cycles; the stable counter compares against its
    // full count so release lands LOCK_STABLE cycles after lock_s rises.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_REL0,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    logic [1:0]       lock_pipe;
    logic             lock_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stab_cnt;
    logic [3:0]       retry_inc;
    logic             timeout;
    logic             lock_done;

    assign lock_s    = lock_pipe[1];
    assign timeout   = (cnt == TIMEOUT_LAST);
    assign lock_done = (stab_cnt == STABLE_DONE);

    // Two-flop synchronizer for the asynchronous PLL lock indicator
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) lock_pipe <= 2'b00;
        else       lock_pipe <= {lock_pipe[0], pll_lock};
    end

    // Saturating next value of the failed-attempt counter
    always_comb begin
        retry_inc = retry_cnt;
        if (retry_cnt != 4'hF) retry_inc = retry_cnt + 4'd1;
    end

    // Sequencer FSM with registered outputs; restart outranks every other event
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state     <= S_HOLD;
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst   <= 1'b1;
            rst_out0  <= 1'b1;
            rst_out1  <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 4'd0;
            fault     <= 1'b0;
        end else if (restart && state != S_FAULT) begin
            state     <= S_HOLD;
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst   <= 1'b1;
            rst_out0  <= 1'b1;
            rst_out1  <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock qualifying on the timeout cycle still wins
                    if (lock_done) begin
                        state    <= S_REL0;
                        cnt      <= '0;
                        stab_cnt <= '0;
                        rst_out0 <= 1'b0;
                    end else if (timeout) begin
                        cnt       <= '0;
                        stab_cnt  <= '0;
                        pll_rst   <= 1'b1;
                        retry_cnt <= retry_inc;
                        if (FAULT_EN && retry_inc >= RETRY_LIMIT) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt      <= cnt + 1'b1;
                        stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
                    end
                end
                S_REL0: begin
                    if (!lock_s) begin
                        state    <= S_HOLD;
                        cnt      <= '0;
                        pll_rst  <= 1'b1;
                        rst_out0 <= 1'b1;
                        rst_out1 <= 1'b1;
                        ready    <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        rst_out1 <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Only a drop seen while fully running is reported as lock_lost
                    if (!lock_s) begin
                        state     <= S_HOLD;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        rst_out0  <= 1'b1;
                        rst_out1  <= 1'b1;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
